// File: rtl/debug_hart_ctrl.sv
// Debug-module side of the hart halt/resume handshake with dmstatus-style flags.
// Optional feature: define DM_RESETHALTREQ_EN to enable halt-on-reset (resethaltreq).
module debug_hart_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic dm_haltreq_i,
    input  logic dm_resumereq_i,
    input  logic dm_ackhavereset_i,
    input  logic dm_setrsthalt_i,
    input  logic dm_clrrsthalt_i,
    input  logic hart_reset_i,
    input  logic halted_i,
    output logic debug_strobe_o,
    output logic resume_req_o,
    output logic halted_o,
    output logic running_o,
    output logic resumeack_o,
    output logic havereset_o,
    output logic busy_o,
    output logic timeout_o
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {RUNNING, HALT_REQ, HALTED, RESUME_REQ} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          resumeack_q, resumeack_d;
    logic          havereset_q, havereset_d;
    logic          timeout_q, timeout_d;
    logic          autohalt_q, autohalt_d;
    logic          hart_reset_q;
    logic          rsthalt_q;
    logic          reset_release;

`ifdef DM_RESETHALTREQ_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni)              rsthalt_q <= 1'b0;
        else if (dm_clrrsthalt_i) rsthalt_q <= 1'b0;
        else if (dm_setrsthalt_i) rsthalt_q <= 1'b1;
    end
`else
    logic unused_rsthalt;
    assign unused_rsthalt = dm_setrsthalt_i ^ dm_clrrsthalt_i;
    assign rsthalt_q      = 1'b0;
`endif

    // First cycle after the hart leaves reset with resethaltreq armed.
    assign reset_release = hart_reset_q & ~hart_reset_i & rsthalt_q;
    assign cnt_inc       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        resumeack_d = resumeack_q;
        timeout_d   = timeout_q;
        autohalt_d  = autohalt_q;
        havereset_d = havereset_q;
        if (dm_ackhavereset_i) havereset_d = 1'b0;
        if (hart_reset_i) begin
            state_d     = RUNNING;
            cnt_d       = '0;
            autohalt_d  = 1'b0;
            havereset_d = 1'b1;
        end else begin
            case (state_q)
                RUNNING: begin
                    if (halted_i) begin
                        state_d = HALTED;
                    end else if (reset_release || dm_haltreq_i) begin
                        state_d    = HALT_REQ;
                        cnt_d      = '0;
                        timeout_d  = 1'b0;
                        autohalt_d = reset_release;
                    end
                end
                HALT_REQ: begin
                    if (halted_i) begin
                        state_d    = HALTED;
                        autohalt_d = 1'b0;
                    end else if (!dm_haltreq_i && !autohalt_q) begin
                        state_d = RUNNING;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_q >= CNT_LAST) timeout_d = 1'b1;
                    end
                end
                HALTED: begin
                    if (dm_resumereq_i && !dm_haltreq_i) begin
                        state_d     = RESUME_REQ;
                        cnt_d       = '0;
                        resumeack_d = 1'b0;
                        timeout_d   = 1'b0;
                    end else if (!halted_i) begin
                        state_d = RUNNING;
                    end
                end
                RESUME_REQ: begin
                    if (!halted_i) begin
                        state_d     = RUNNING;
                        resumeack_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_q >= CNT_LAST) timeout_d = 1'b1;
                    end
                end
                default: state_d = RUNNING;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= RUNNING;
            cnt_q        <= '0;
            resumeack_q  <= 1'b0;
            havereset_q  <= 1'b1;
            timeout_q    <= 1'b0;
            autohalt_q   <= 1'b0;
            hart_reset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resumeack_q  <= resumeack_d;
            havereset_q  <= havereset_d;
            timeout_q    <= timeout_d;
            autohalt_q   <= autohalt_d;
            hart_reset_q <= hart_reset_i;
        end
    end

    assign debug_strobe_o = (state_q == HALT_REQ);
    assign resume_req_o   = (state_q == RESUME_REQ);
    assign halted_o       = (state_q == HALTED);
    assign running_o      = ~halted_o & ~hart_reset_i;
    assign busy_o         = debug_strobe_o | resume_req_o;
    assign resumeack_o    = resumeack_q;
    assign havereset_o    = havereset_q;
    assign timeout_o      = timeout_q;
endmodule

// File: tb/tb_debug_hart_ctrl.sv
// Bench for debug_hart_ctrl: directed vector table, hand sequences for timeouts,
// then randomized traffic against a cycle-stamped reference model.
module tb_debug_hart_ctrl;
    localparam int T = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0, haltreq = 1'b0, resumereq = 1'b0, ack = 1'b0;
    logic setr = 1'b0, clrr = 1'b0, hr = 1'b0, halted = 1'b0;
    logic strobe, rreq, halted_o, running, rack, hv, busy, to;

    always #5 clk = ~clk;

    debug_hart_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk), .rst_ni(rst_n), .dm_haltreq_i(haltreq), .dm_resumereq_i(resumereq),
        .dm_ackhavereset_i(ack), .dm_setrsthalt_i(setr), .dm_clrrsthalt_i(clrr),
        .hart_reset_i(hr), .halted_i(halted), .debug_strobe_o(strobe), .resume_req_o(rreq),
        .halted_o(halted_o), .running_o(running), .resumeack_o(rack), .havereset_o(hv),
        .busy_o(busy), .timeout_o(to)
    );

    // inputs {rst_n, haltreq, resumereq, ack, hr, halted}
    // outputs {strobe, resume_req, halted, running, resumeack, havereset, busy, timeout}
    typedef struct packed {
        logic [5:0] in;
        logic [7:0] exp;
    } vec_t;

    int n_chk = 0, n_pass = 0;

    function automatic logic [7:0] outs();
        return {strobe, rreq, halted_o, running, rack, hv, busy, to};
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, got, exp);
    endtask

    task automatic apply(input logic [5:0] in);
        {rst_n, haltreq, resumereq, ack, hr, halted} = in;
        @(posedge clk); #1;
    endtask

    // Reference model: modes 0 run, 1 halt request, 2 halted, 3 resume request.
    // Request age is tracked by the edge number at which the request started.
    int m_mode = 0, m_start = 0, cyc = 0;
    bit m_ack = 0, m_hv = 1, m_to = 0, m_flag = 0, m_prev_hr = 0, m_auto = 0;

    task automatic model_step();
        bit rel;
        cyc++;
        if (!rst_n) begin
            m_mode = 0; m_ack = 0; m_hv = 1; m_to = 0; m_flag = 0; m_prev_hr = 0; m_auto = 0;
            return;
        end
        rel = m_prev_hr && !hr && m_flag;
        if (ack) m_hv = 0;
        if (hr) begin
            m_mode = 0; m_hv = 1; m_auto = 0;
        end else if (m_mode == 0) begin
            if (halted) m_mode = 2;
            else if (rel || haltreq) begin m_mode = 1; m_start = cyc; m_to = 0; m_auto = rel; end
        end else if (m_mode == 1) begin
            if (halted) begin m_mode = 2; m_auto = 0; end
            else if (!haltreq && !m_auto) m_mode = 0;
            else if (cyc - m_start >= T) m_to = 1;
        end else if (m_mode == 2) begin
            if (resumereq && !haltreq) begin m_mode = 3; m_start = cyc; m_ack = 0; m_to = 0; end
            else if (!halted) m_mode = 0;
        end else begin
            if (!halted) begin m_mode = 0; m_ack = 1; end
            else if (cyc - m_start >= T) m_to = 1;
        end
`ifdef DM_RESETHALTREQ_EN
        if (clrr) m_flag = 0;
        else if (setr) m_flag = 1;
`endif
        m_prev_hr = hr;
    endtask

    function automatic logic [7:0] model_exp();
        return {m_mode == 1, m_mode == 3, m_mode == 2, (m_mode != 2) && !hr,
                m_ack, m_hv, (m_mode == 1) || (m_mode == 3), m_to};
    endfunction

    vec_t tbl[22];

    initial begin
        tbl[0]  = '{6'b0_00000, 8'b0001_0100};
        tbl[1]  = '{6'b1_00100, 8'b0001_0000};
        tbl[2]  = '{6'b1_10000, 8'b1001_0010};
        tbl[3]  = '{6'b1_10000, 8'b1001_0010};
        tbl[4]  = '{6'b1_10000, 8'b1001_0010};
        tbl[5]  = '{6'b1_10001, 8'b0010_0000};
        tbl[6]  = '{6'b1_01001, 8'b0101_0010};
        tbl[7]  = '{6'b1_00001, 8'b0101_0010};
        tbl[8]  = '{6'b1_00000, 8'b0001_1000};
        tbl[9]  = '{6'b1_00001, 8'b0010_1000};
        tbl[10] = '{6'b1_11001, 8'b0010_1000};
        tbl[11] = '{6'b1_00001, 8'b0010_1000};
        tbl[12] = '{6'b1_00000, 8'b0001_1000};
        tbl[13] = '{6'b1_10000, 8'b1001_1010};
        tbl[14] = '{6'b1_10000, 8'b1001_1010};
        tbl[15] = '{6'b1_00000, 8'b0001_1000};
        tbl[16] = '{6'b1_00010, 8'b0000_1100};
        tbl[17] = '{6'b1_10010, 8'b0000_1100};
        tbl[18] = '{6'b1_00000, 8'b0001_1100};
        tbl[19] = '{6'b1_00100, 8'b0001_1000};
        tbl[20] = '{6'b1_00110, 8'b0000_1100};
        tbl[21] = '{6'b1_00000, 8'b0001_1100};

        for (int i = 0; i < 22; i++) begin
            apply(tbl[i].in);
            check($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end

        // Halt request never acknowledged: 8 strobe cycles, then sticky timeout.
        for (int i = 1; i <= 8; i++) begin
            apply(6'b1_10000);
            check($sformatf("halt_to_wait%0d", i), outs(), 8'b1001_1110);
        end
        apply(6'b1_10000); check("halt_to_set", outs(), 8'b1001_1111);
        apply(6'b1_00000); check("halt_to_sticky", outs(), 8'b0001_1101);
        apply(6'b1_10000); check("halt_to_clear", outs(), 8'b1001_1110);
        apply(6'b1_00000); check("halt_abort", outs(), 8'b0001_1100);

        // Resume request never acknowledged.
        apply(6'b1_00001); check("ebreak_halt", outs(), 8'b0010_1100);
        apply(6'b1_01001); check("resume_enter", outs(), 8'b0101_0110);
        for (int i = 2; i <= 8; i++) begin
            apply(6'b1_00001);
            check($sformatf("res_to_wait%0d", i), outs(), 8'b0101_0110);
        end
        apply(6'b1_00001); check("res_to_set", outs(), 8'b0101_0111);
        apply(6'b1_00000); check("res_done", outs(), 8'b0001_1101);

`ifdef DM_RESETHALTREQ_EN
        setr = 1'b1; apply(6'b1_00000); setr = 1'b0;
        for (int i = 0; i < 4; i++) apply(6'b1_00010);
        check("rh_in_reset", outs(), 8'b0000_1101);
        apply(6'b1_00000); check("rh_auto_halt", outs(), 8'b1001_1110);
        apply(6'b1_00100); check("rh_no_abort_ack", outs(), 8'b1001_1010);
        apply(6'b1_00001); check("rh_halted", outs(), 8'b0010_1000);
        clrr = 1'b1; apply(6'b1_00000); clrr = 1'b0;
        check("rh_exit", outs(), 8'b0001_1000);
`endif

        // Randomized traffic against the reference model.
        rst_n = 1'b0; haltreq = 0; resumereq = 0; ack = 0; setr = 0; clrr = 0; hr = 0; halted = 0;
        model_step(); @(posedge clk); #1;
        check("rand_reset", outs(), model_exp());
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 9) == 0) haltreq = ~haltreq;
            resumereq = ($urandom_range(0, 5) == 0);
            ack       = ($urandom_range(0, 15) == 0);
            setr      = ($urandom_range(0, 19) == 0);
            clrr      = ($urandom_range(0, 29) == 0);
            if (hr) hr = ($urandom_range(0, 3) != 0);
            else    hr = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 11) == 0) halted = ~halted;
            model_step();
            @(posedge clk); #1;
            check($sformatf("rand%0d", i), outs(), model_exp());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
